// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file writeback port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned DEF_DW   = 32;
    localparam int unsigned DEF_AW   = 5;
    localparam int unsigned REG_ZERO = 0;
    localparam logic        SRC_A    = 1'b0;
    localparam logic        SRC_B    = 1'b1;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_A,
        GNT_B
    } grant_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding out-of-band writeback entries.
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    output logic             pushReady,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    // Fullness comes from the start-of-cycle count, so a pop never frees room for a same-cycle push.
    assign pushReady = (count < CW'(DEPTH));
    assign doPush    = push && pushReady;
    assign doPop     = pop && (count != '0);
    assign headData  = mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (A)
// and buffered out-of-band results (B), with a starvation limit protecting B.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned B_DEPTH      = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned CW          = $clog2(B_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [AW-1:0] a_dest,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_dest,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic [CW-1:0] b_count,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_wsrc
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    grant_t        grant;
    logic [SW-1:0] starveCnt;
    logic [SW-1:0] starveCntNext;
    logic          bPending;
    logic          forceB;
    logic [AW-1:0] headDest;
    logic [DW-1:0] headData;

    wb_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (B_DEPTH)
    ) bFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (b_valid),
        .pushData  ({b_dest, b_data}),
        .pushReady (b_ready),
        .pop       (grant == GNT_B),
        .headData  ({headDest, headData}),
        .count     (b_count)
    );

    assign bPending = (b_count != '0);
    assign forceB   = bPending && (starveCnt == StarveMax);
    assign a_ready  = !forceB;

    always_comb begin
        grant = GNT_IDLE;
        if (bPending && (forceB || !a_valid)) begin
            grant = GNT_B;
        end else if (a_valid) begin
            grant = GNT_A;
        end
    end

    always_comb begin
        starveCntNext = starveCnt;
        if (grant == GNT_B || !bPending) begin
            starveCntNext = '0;
        end else if (grant == GNT_A && starveCnt != StarveMax) begin
            starveCntNext = starveCnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
        end else begin
            starveCnt <= starveCntNext;
        end
    end

    // Writes to $0 are consumed like any other grant but never assert the enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_wsrc  <= SRC_A;
        end else begin
            case (grant)
                GNT_A: begin
                    rf_we    <= (a_dest != AW'(REG_ZERO));
                    rf_waddr <= a_dest;
                    rf_wdata <= a_data;
                    rf_wsrc  <= SRC_A;
                end
                GNT_B: begin
                    rf_we    <= (headDest != AW'(REG_ZERO));
                    rf_waddr <= headDest;
                    rf_wdata <= headData;
                    rf_wsrc  <= SRC_B;
                end
                default: begin
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_dest;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_dest;
    logic [31:0] b_data;
    logic        b_ready;
    logic [1:0]  b_count;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wsrc;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .DW           (32),
        .AW           (5),
        .B_DEPTH      (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_dest   (a_dest),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_dest   (b_dest),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .b_count  (b_count),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_wsrc  (rf_wsrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRf(input string tag, input logic we, input logic [4:0] addr,
                           input logic [31:0] data, input logic src);
        check({tag, ".we"},    64'(rf_we),    64'(we));
        check({tag, ".waddr"}, 64'(rf_waddr), 64'(addr));
        check({tag, ".wdata"}, 64'(rf_wdata), 64'(data));
        check({tag, ".wsrc"},  64'(rf_wsrc),  64'(src));
    endtask

    // Starvation scenario: expected a_ready per cycle and the write that follows each cycle.
    logic       expReady [7] = '{1, 1, 1, 1, 1, 0, 1};
    logic [4:0] expAddr  [7] = '{10, 11, 12, 13, 14, 9, 15};
    logic       expSrc   [7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        int k;
        reset   = 1'b1;
        a_valid = 1'b0;
        a_dest  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_dest  = '0;
        b_data  = '0;
        #12;
        checkRf("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        check("reset.b_count", 64'(b_count), 64'd0);
        check("reset.b_ready", 64'(b_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // A only
        a_valid = 1'b1; a_dest = 5'd5; a_data = 32'h0000_1234;
        #1;
        check("a_only.a_ready", 64'(a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
        checkRf("a_only.write", 1'b1, 5'd5, 32'h1234, 1'b0);
        tick();
        checkRf("a_only.idle", 1'b0, 5'd5, 32'h1234, 1'b0);

        // B only, two back-to-back pushes
        b_valid = 1'b1; b_dest = 5'd3; b_data = 32'hAAAA;
        #1;
        check("b_only.b_ready", 64'(b_ready), 64'd1);
        tick();
        check("b_only.count1", 64'(b_count), 64'd1);
        check("b_only.no_bypass", 64'(rf_we), 64'd0);
        b_dest = 5'd7; b_data = 32'hBBBB;
        tick();
        b_valid = 1'b0;
        checkRf("b_only.reg3", 1'b1, 5'd3, 32'hAAAA, 1'b1);
        check("b_only.count_pushpop", 64'(b_count), 64'd1);
        tick();
        checkRf("b_only.reg7", 1'b1, 5'd7, 32'hBBBB, 1'b1);
        check("b_only.count0", 64'(b_count), 64'd0);
        tick();
        checkRf("b_only.idle", 1'b0, 5'd7, 32'hBBBB, 1'b1);

        // Starvation: continuous A, one B entry pushed in the first cycle
        k = 0;
        for (int c = 0; c < 7; c++) begin
            a_valid = 1'b1;
            a_dest  = 5'(10 + k);
            a_data  = 32'h100 + 32'(10 + k);
            b_valid = (c == 0);
            b_dest  = 5'd9;
            b_data  = 32'h9999;
            #1;
            check($sformatf("starve.a_ready[%0d]", c), 64'(a_ready), 64'(expReady[c]));
            tick();
            if (expReady[c]) k++;
            checkRf($sformatf("starve.w[%0d]", c), 1'b1, expAddr[c],
                    expSrc[c] ? 32'h9999 : 32'h100 + 32'(expAddr[c]), expSrc[c]);
        end
        check("starve.cnt_cleared", 64'(dut.starveCnt), 64'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("starve.idle", 64'(rf_we), 64'd0);

        // Full FIFO: third push ignored, also when a pop happens the same cycle
        a_valid = 1'b1; a_dest = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_dest = 5'd20; b_data = 32'h2020;
        tick();
        b_dest = 5'd21; b_data = 32'h2121;
        tick();
        b_dest = 5'd22; b_data = 32'h2222;
        #1;
        check("full.count2", 64'(b_count), 64'd2);
        check("full.b_ready0", 64'(b_ready), 64'd0);
        tick();
        a_valid = 1'b0;
        #1;
        check("full.still2", 64'(b_count), 64'd2);
        check("full.still_not_ready", 64'(b_ready), 64'd0);
        tick();
        b_valid = 1'b0;
        check("full.pop_no_push", 64'(b_count), 64'd1);
        checkRf("full.e20", 1'b1, 5'd20, 32'h2020, 1'b1);
        tick();
        checkRf("full.e21", 1'b1, 5'd21, 32'h2121, 1'b1);
        check("full.empty", 64'(b_count), 64'd0);
        tick();
        check("full.no_e22", 64'(rf_we), 64'd0);
        check("full.no_e22_addr", 64'(rf_waddr), 64'd21);

        // Dest $0 on both ports
        a_valid = 1'b1; a_dest = 5'd0; a_data = 32'hFFFF;
        #1;
        check("dest0.a_ready", 64'(a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
        checkRf("dest0.a", 1'b0, 5'd0, 32'hFFFF, 1'b0);
        b_valid = 1'b1; b_dest = 5'd0; b_data = 32'h5555;
        tick();
        b_valid = 1'b0;
        check("dest0.b_count1", 64'(b_count), 64'd1);
        tick();
        check("dest0.b_popped", 64'(b_count), 64'd0);
        checkRf("dest0.b", 1'b0, 5'd0, 32'h5555, 1'b1);

        // Reset mid-operation with two buffered entries
        a_valid = 1'b1; a_dest = 5'd2; a_data = 32'h22;
        b_valid = 1'b1; b_dest = 5'd25; b_data = 32'h2525;
        tick();
        b_dest = 5'd26; b_data = 32'h2626;
        tick();
        check("rst.count2", 64'(b_count), 64'd2);
        check("rst.we_before", 64'(rf_we), 64'd1);
        reset = 1'b1;
        #1;
        check("rst.we_async", 64'(rf_we), 64'd0);
        check("rst.count_async", 64'(b_count), 64'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.b_ready", 64'(b_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("rst.no_stale[%0d]", c), 64'(rf_we), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
